// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_BAUD_W     = 16;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Push-side interface of the UART byte transmitter: byte strobe in, status back.
interface uart_byte_tx_if;
  import uart_pkg::*;

  logic                      txen;
  logic [UART_DATA_BITS-1:0] txpcdata;
  logic                      busy;
  logic                      fifo_full;
  logic                      overflow;

  modport master (
    output txen,
    output txpcdata,
    input  busy,
    input  fifo_full,
    input  overflow
  );

  modport slave (
    input  txen,
    input  txpcdata,
    output busy,
    output fifo_full,
    output overflow
  );

endinterface

// File: rtl/uart_byte_tx_fifo.sv
// Small synchronous byte FIFO: registered count and flags, pushes to a full
// FIFO are dropped and latch a sticky overflow flag.
module sync_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [UART_DATA_BITS-1:0] wdata_i,
  input  logic                      pop_i,
  output logic [UART_DATA_BITS-1:0] rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      nxt_empty_o,
  output logic                      overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      full_q, full_d;
  logic                      empty_q, empty_d;
  logic                      ovf_q, ovf_d;
  logic                      push_ok;
  logic                      pop_ok;

  // Fullness is judged on the pre-edge flags, so a same-edge pop never rescues a push.
  always_comb begin
    push_ok  = push_i & ~full_q;
    pop_ok   = pop_i & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push_i & full_q);

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CNT_DEPTH);
    empty_d = (count_d == CNT_ZERO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o     = mem_q[rd_ptr_q];
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign nxt_empty_o = empty_d;
  assign overflow_o  = ovf_q;

endmodule

// File: rtl/uart_byte_tx.sv
// Buffered UART 8N1 byte transmitter, LSB first. Defining UART_TX_PARITY_EN
// inserts an even-parity bit between the data bits and the stop bit.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_byte_tx_if.slave  bus,
  output logic           tx
);

  localparam logic [UART_BAUD_W-1:0] BAUD_LAST = UART_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [UART_BAUD_W-1:0] BAUD_ONE  = UART_BAUD_W'(1);
  localparam logic [2:0]             BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [UART_BAUD_W-1:0]    baud_q, baud_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  logic                      fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic                      fifo_empty;
  logic                      fifo_nxt_empty;
  logic                      fifo_full;
  logic                      fifo_ovf;
  logic                      bit_end;

  sync_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (bus.txen),
    .wdata_i     (bus.txpcdata),
    .pop_i       (fifo_pop),
    .rdata_o     (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .nxt_empty_o (fifo_nxt_empty),
    .overflow_o  (fifo_ovf)
  );

  assign bit_end = (baud_q == BAUD_LAST);

  // tx_d follows the current state, so the line register lags the FSM by one cycle.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    tx_d      = UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        tx_d = UART_IDLE_LEVEL;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(fifo_rdata);
`endif
          baud_d   = '0;
          state_d  = START;
        end else begin
          state_d  = IDLE;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          baud_d    = baud_q + BAUD_ONE;
        end
      end

      DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = parity_q;
        if (bit_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d  = baud_q + BAUD_ONE;
        end
      end
`endif

      STOP: begin
        tx_d = UART_IDLE_LEVEL;
        if (bit_end) begin
          baud_d = '0;
          // A queued byte starts its frame straight after this stop bit.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
            parity_d = even_parity(fifo_rdata);
`endif
            state_d  = START;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      default: begin
        tx_d    = UART_IDLE_LEVEL;
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE) | ~fifo_nxt_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx            = tx_q;
  assign bus.busy      = busy_q;
  assign bus.fifo_full = fifo_full;
  assign bus.overflow  = fifo_ovf;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: frame-timeline reference model checked
// every cycle, a table of single-byte frames, and directed corner sequences.
module tb_uart_byte_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int FLEN = FRAME * CPB;

  logic clk = 1'b0;
  logic rst;
  logic tx;

  uart_byte_tx_if bus ();

  uart_byte_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: byte queue plus the edge at which the current frame was popped.
  logic [7:0] m_q[$];
  int         k = 0;
  int         m_pop_edge = 0;
  bit         m_active = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic       m_tx = 1'b1, m_busy = 1'b0, m_full = 1'b0, m_ovf = 1'b0;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [7:0] d);
    int pre;
    bit in_frame;
    bit do_pop;
    k++;
    if (r) begin
      m_q.delete();
      m_active = 1'b0;
      m_ovf    = 1'b0;
      m_tx     = 1'b1;
      m_busy   = 1'b0;
    end else begin
      in_frame = m_active && (k > m_pop_edge) && (k <= m_pop_edge + FLEN);
      m_tx     = in_frame ? frame_bit(m_byte, (k - m_pop_edge - 1) / CPB) : 1'b1;
      pre      = m_q.size();
      do_pop   = (pre > 0) && (!in_frame || (k == m_pop_edge + FLEN));
      if (do_pop) begin
        m_byte     = m_q.pop_front();
        m_pop_edge = k;
        m_active   = 1'b1;
      end
      if (e) begin
        if (pre == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(d);
      end
      m_busy = (m_active && (k < m_pop_edge + FLEN)) || (m_q.size() > 0);
    end
    m_full = (m_q.size() == DEPTH);
  endtask

  task automatic cycle(input logic r, input logic e, input logic [7:0] d);
    logic [3:0] got;
    logic [3:0] exp;
    rst          = r;
    bus.txen     = e;
    bus.txpcdata = d;
    @(posedge clk);
    #1;
    model_step(r, e, d);
    got = {tx, bus.busy, bus.fifo_full, bus.overflow};
    exp = {m_tx, m_busy, m_full, m_ovf};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL outputs edge %0d {tx,busy,full,ovf}: got %b expected %b", k, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [10:0] line;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [10:0] got_line;
    logic        tx_hist[0:63];
    logic        busy_hist[0:63];
    int          lows;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
    vecs[1] = '{8'h00, 11'b1_0_00000000_0};
    vecs[2] = '{8'hFF, 11'b1_0_11111111_0};
    vecs[3] = '{8'h07, 11'b1_1_00000111_0};
    vecs[4] = '{8'h03, 11'b1_0_00000011_0};
    vecs[5] = '{8'h80, 11'b1_1_10000000_0};
`else
    vecs[0] = '{8'hA5, 11'b0_1_10100101_0};
    vecs[1] = '{8'h00, 11'b0_1_00000000_0};
    vecs[2] = '{8'hFF, 11'b0_1_11111111_0};
    vecs[3] = '{8'h07, 11'b0_1_00000111_0};
    vecs[4] = '{8'h03, 11'b0_1_00000011_0};
    vecs[5] = '{8'h80, 11'b0_1_10000000_0};
`endif

    // Reset, then a quiet line.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    idle(50);

    // Single frames from idle: latency, mid-bit samples, busy at frame end.
    for (int v = 0; v < 6; v++) begin
      idle(8);
      cycle(1'b0, 1'b1, vecs[v].data);
      for (int j = 1; j <= FLEN + 2; j++) begin
        cycle(1'b0, 1'b0, 8'h00);
        tx_hist[j]   = tx;
        busy_hist[j] = bus.busy;
      end
      got_line = '0;
      for (int i = 0; i < FRAME; i++) got_line[i] = tx_hist[2 + i * CPB + CPB / 2];
      checks++;
      if (got_line !== vecs[v].line) begin
        errors++;
        $display("FAIL frame_bits %h: got %b expected %b", vecs[v].data, got_line, vecs[v].line);
      end
      checks++;
      if ({tx_hist[1], tx_hist[2]} !== 2'b10) begin
        errors++;
        $display("FAIL start_latency %h: got %b expected 10", vecs[v].data, {tx_hist[1], tx_hist[2]});
      end
      checks++;
      if ({busy_hist[FLEN], busy_hist[FLEN + 1]} !== 2'b10) begin
        errors++;
        $display("FAIL frame_length %h: busy got %b expected 10",
                 vecs[v].data, {busy_hist[FLEN], busy_hist[FLEN + 1]});
      end
    end

    // Four back-to-back pushes: contiguous frames, never full.
    idle(5);
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 8'(i));
    idle(4 * FLEN + 10);

    // Six back-to-back pushes: the last one is dropped, overflow sticks.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'(8'h10 + i));
    idle(5 * FLEN + 10);
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b expected 1", bus.overflow);
    end

    // Reset in the middle of a 0xFF frame with another byte queued.
    cycle(1'b0, 1'b1, 8'hFF);
    cycle(1'b0, 1'b1, 8'h5A);
    idle(20);
    cycle(1'b1, 1'b0, 8'h00);
    checks++;
    if ({tx, bus.busy, bus.fifo_full, bus.overflow} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_abort: got %b expected 1000", {tx, bus.busy, bus.fifo_full, bus.overflow});
    end
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL after_reset_quiet: got %0d low cycles expected 0", lows);
    end

    // Random traffic at several push rates with rare resets.
    for (int blk = 0; blk < 3; blk++) begin
      int rate;
      rate = (blk == 0) ? 3 : ((blk == 1) ? 10 : 40);
      for (int i = 0; i < 1500; i++) begin
        cycle(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < rate) ? 1'b1 : 1'b0,
              8'($urandom));
      end
    end
    idle(DEPTH * FLEN + 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Downstream stage of the RAM-to-PC dump path.
- Consumes the one-cycle `txen` strobe and the `txpcdata` byte produced by the RAM readout/sequencer block.
- Buffers bytes in a small FIFO and serialises each one as a UART 8N1 frame on the `tx` pin, LSB first.
- Decouples the upstream fixed byte pacing from the actual baud timing.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- txen  in  1  one-cycle strobe: txpcdata valid, push request.
- txpcdata  in  8  byte to transmit.
- tx  out  1  UART serial line; idles high.
- busy  out  1  high when FIFO non-empty or a frame is in progress.
- fifo_full  out  1  FIFO holds FIFO_DEPTH bytes.
- overflow  out  1  sticky: a push was dropped because the FIFO was full.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: tx=1, busy=0, fifo_full=0, overflow=0; FIFO pointers and count=0; state=IDLE; bit and baud counters=0.
- Reset mid-frame aborts the frame and flushes the FIFO; tx is high from the first edge with rst=1.
- Push:
  - On a rising edge with txen=1 and count<FIFO_DEPTH, the byte is written.
  - With count==FIFO_DEPTH, the byte is dropped and overflow is set; overflow holds until rst.
  - Fullness is judged on the pre-edge count, so a push to a full FIFO is dropped even if a pop occurs on the same edge.
  - Push and pop on the same edge on a non-full, non-empty FIFO leave count unchanged.
- State machine:
  - IDLE:
    - tx=1.
    - If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the baud counter, and go to START.
    - An empty FIFO does not pop, even with a same-edge push; the pushed byte is seen next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - tx=shift[0] for CLKS_PER_BIT cycles per bit.
    - Shift right after each bit.
    - After bit index 7, go to STOP (or PARITY, see Optional Feature).
  - STOP:
    - tx=1 for CLKS_PER_BIT cycles.
    - On the last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1, 16 bits wide, and wraps to 0 at each bit boundary.
- Latency: with an idle block and empty FIFO, txen sampled at edge N causes tx to go low at edge N+2. The frame is exactly 10*CLKS_PER_BIT cycles long.
- Back-to-back queued bytes produce contiguous frames.
- busy is registered and reflects the post-edge state and count.
- tx is driven from a register; it is glitch-free.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame is 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, no parity logic; 8N1 framing as above.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constants UART_IDLE_LEVEL=1, UART_DATA_BITS=8;
  - localparam for the baud-counter width.
- Sub-module sync_byte_fifo (parameter DEPTH): registered count, full/empty flags, and the drop-on-full rule.
- The FSM and shifter stay in uart_byte_tx.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset then idle 50 cycles -> tx=1, busy=0, overflow=0 throughout.
- Single txen with byte 0xA5 -> tx falls 2 edges later; sampled mid-bit sequence 0,1,0,1,0,0,1,0,1,1; frame length 40 cycles; then busy=0.
- Four txen on consecutive cycles with 0x01, 0x02, 0x03, 0x04 -> four contiguous 40-cycle frames with no idle gap; fifo_full never asserts; overflow=0.
- Six consecutive txen with 0x10..0x15 -> 0x10 popped, 0x11..0x14 queued; 0x15 dropped, overflow=1 and sticky; 5 frames transmitted.
- rst asserted at cycle 20 of a 0xFF frame -> tx=1 on the next edge; FIFO empty; no further frames; overflow cleared.
- With UART_TX_PARITY_EN, byte 0x07 -> parity bit 1, frame length 44 cycles; byte 0x03 -> parity bit 0.
